// File: rtl/network_request_initiator.sv
// Requester-side network interface: turns one core load/store into a router packet and waits for the matching reply.
// Optional timeout/retry logic is enabled by defining NI_TIMEOUT_EN.
`ifndef NETWORK_ADDRESS_WIDTH
`define NETWORK_ADDRESS_WIDTH 4
`endif
`ifndef CACHE_BANK_ADDRESS_WIDTH
`define CACHE_BANK_ADDRESS_WIDTH 8
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module network_request_initiator #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int MAX_RETRIES    = 2
) (
  input  logic                                                        clk,
  input  logic                                                        reset,
  input  logic [`NETWORK_ADDRESS_WIDTH-1:0]                           localRouterAddress,
  input  logic                                                        coreReq,
  input  logic                                                        coreWrite,
  input  logic [`NETWORK_ADDRESS_WIDTH+`CACHE_BANK_ADDRESS_WIDTH-1:0] coreAddress,
  input  logic [`DATA_WIDTH-1:0]                                      coreWriteData,
  output logic                                                        coreReady,
  output logic                                                        coreRespValid,
  output logic [`DATA_WIDTH-1:0]                                      coreRespData,
  output logic                                                        coreError,
  output logic [`NETWORK_ADDRESS_WIDTH+`CACHE_BANK_ADDRESS_WIDTH-1:0] destinationAddressOut,
  output logic [`NETWORK_ADDRESS_WIDTH-1:0]                           requesterAddressOut,
  output logic                                                        readOut,
  output logic                                                        writeOut,
  output logic [`DATA_WIDTH-1:0]                                      dataOut,
  input  logic                                                        networkReady,
  input  logic                                                        replyValid,
  input  logic [`NETWORK_ADDRESS_WIDTH-1:0]                           replyRequesterAddress,
  input  logic                                                        replyWriteAck,
  input  logic [`DATA_WIDTH-1:0]                                      replyData,
  output logic [7:0]                                                  droppedReplies
);

  localparam int NAW  = `NETWORK_ADDRESS_WIDTH;
  localparam int CBAW = `CACHE_BANK_ADDRESS_WIDTH;
  localparam int DW   = `DATA_WIDTH;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] SEND      = 2'd1;
  localparam logic [1:0] WAIT_RESP = 2'd2;
  localparam logic [1:0] RESPOND   = 2'd3;

  logic [1:0] state_r;
  logic [1:0] nextState_s;
  logic       latchedWrite_r;
  logic       match_s;
  logic       timeout_s;
  logic       retryAllowed_s;

  assign coreReady = (state_r == IDLE);
  assign match_s   = (state_r == WAIT_RESP) && replyValid &&
                     (replyRequesterAddress == localRouterAddress) &&
                     (replyWriteAck == latchedWrite_r);

`ifdef NI_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int RW = $clog2(MAX_RETRIES + 2);

  logic [TW-1:0] timer_r;
  logic [RW-1:0] retryCount_r;
  logic          respError_r;

  assign timeout_s      = (state_r == WAIT_RESP) && (timer_r == TW'(TIMEOUT_CYCLES - 1));
  assign retryAllowed_s = (retryCount_r < RW'(MAX_RETRIES));
  assign coreError      = respError_r;

  // Wait timer, resend counter and error flag for the timeout path
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer_r      <= '0;
      retryCount_r <= '0;
      respError_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          retryCount_r <= '0;
          respError_r  <= 1'b0;
        end
        SEND: begin
          timer_r <= '0;
        end
        WAIT_RESP: begin
          timer_r <= timer_r + TW'(1);
          if (!match_s && timeout_s) begin
            if (retryAllowed_s) begin
              retryCount_r <= retryCount_r + RW'(1);
            end else begin
              respError_r <= 1'b1;
            end
          end
        end
        RESPOND: begin
          respError_r <= 1'b0;
        end
        default: begin
          timer_r <= '0;
        end
      endcase
    end
  end
`else
  logic [31:0] unusedParams_s;

  assign unusedParams_s = TIMEOUT_CYCLES ^ MAX_RETRIES;
  assign timeout_s      = 1'b0;
  assign retryAllowed_s = 1'b0;
  assign coreError      = 1'b0;
`endif

  // Next-state decode; a reply match takes priority over a timeout
  always_comb begin
    nextState_s = state_r;
    case (state_r)
      IDLE: begin
        if (coreReq) nextState_s = SEND;
        else         nextState_s = IDLE;
      end
      SEND: begin
        if (networkReady) nextState_s = WAIT_RESP;
        else              nextState_s = SEND;
      end
      WAIT_RESP: begin
        if (match_s)             nextState_s = RESPOND;
        else if (timeout_s) begin
          if (retryAllowed_s)    nextState_s = SEND;
          else                   nextState_s = RESPOND;
        end else                 nextState_s = WAIT_RESP;
      end
      RESPOND: nextState_s = IDLE;
      default: nextState_s = IDLE;
    endcase
  end

  // State register, packet outputs and core response
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r               <= IDLE;
      latchedWrite_r        <= 1'b0;
      destinationAddressOut <= '0;
      requesterAddressOut   <= '0;
      dataOut               <= '0;
      readOut               <= 1'b0;
      writeOut              <= 1'b0;
      coreRespValid         <= 1'b0;
      coreRespData          <= '0;
    end else begin
      state_r       <= nextState_s;
      coreRespValid <= 1'b0;
      case (state_r)
        IDLE: begin
          if (coreReq) begin
            destinationAddressOut <= coreAddress;
            requesterAddressOut   <= localRouterAddress;
            dataOut               <= coreWriteData;
            latchedWrite_r        <= coreWrite;
            readOut               <= ~coreWrite;
            writeOut              <= coreWrite;
          end
        end
        SEND: begin
          if (networkReady) begin
            readOut  <= 1'b0;
            writeOut <= 1'b0;
          end
        end
        WAIT_RESP: begin
          if (match_s) begin
            coreRespValid <= 1'b1;
            coreRespData  <= latchedWrite_r ? {DW{1'b0}} : replyData;
          end else if (timeout_s) begin
            if (retryAllowed_s) begin
              // Resend the identical packet from the latched fields
              readOut  <= ~latchedWrite_r;
              writeOut <= latchedWrite_r;
            end else begin
              coreRespValid <= 1'b1;
              coreRespData  <= {DW{1'b0}};
            end
          end
        end
        RESPOND: begin
          coreRespValid <= 1'b0;
        end
        default: begin
          readOut  <= 1'b0;
          writeOut <= 1'b0;
        end
      endcase
    end
  end

  // Saturating count of every reply that is not consumed as a match
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      droppedReplies <= 8'h00;
    end else if (replyValid && !match_s && (droppedReplies != 8'hFF)) begin
      droppedReplies <= droppedReplies + 8'h01;
    end
  end

endmodule

// File: tb/tb_network_request_initiator.sv
// Directed-vector bench for network_request_initiator (NAW=4, CBAW=8, DW=32).
// Timeout/retry scenario runs only when NI_TIMEOUT_EN is defined.
module tb_network_request_initiator;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  localRouterAddress;
  logic        coreReq;
  logic        coreWrite;
  logic [11:0] coreAddress;
  logic [31:0] coreWriteData;
  logic        coreReady;
  logic        coreRespValid;
  logic [31:0] coreRespData;
  logic        coreError;
  logic [11:0] destinationAddressOut;
  logic [3:0]  requesterAddressOut;
  logic        readOut;
  logic        writeOut;
  logic [31:0] dataOut;
  logic        networkReady;
  logic        replyValid;
  logic [3:0]  replyRequesterAddress;
  logic        replyWriteAck;
  logic [31:0] replyData;
  logic [7:0]  droppedReplies;

  int vectors = 0;
  int miscompares = 0;

  network_request_initiator #(.TIMEOUT_CYCLES(8), .MAX_RETRIES(2)) dut (
    .clk(clk), .reset(reset), .localRouterAddress(localRouterAddress),
    .coreReq(coreReq), .coreWrite(coreWrite), .coreAddress(coreAddress),
    .coreWriteData(coreWriteData), .coreReady(coreReady), .coreRespValid(coreRespValid),
    .coreRespData(coreRespData), .coreError(coreError),
    .destinationAddressOut(destinationAddressOut), .requesterAddressOut(requesterAddressOut),
    .readOut(readOut), .writeOut(writeOut), .dataOut(dataOut), .networkReady(networkReady),
    .replyValid(replyValid), .replyRequesterAddress(replyRequesterAddress),
    .replyWriteAck(replyWriteAck), .replyData(replyData), .droppedReplies(droppedReplies)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic request(input logic wr, input logic [11:0] addr, input logic [31:0] wdata);
    coreReq = 1'b1; coreWrite = wr; coreAddress = addr; coreWriteData = wdata;
    tick();
    coreReq = 1'b0;
  endtask

  task automatic reply(input logic [3:0] req, input logic ack, input logic [31:0] data);
    replyValid = 1'b1; replyRequesterAddress = req; replyWriteAck = ack; replyData = data;
    tick();
    replyValid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; localRouterAddress = 4'h5; coreReq = 1'b0; coreWrite = 1'b0;
    coreAddress = 12'h000; coreWriteData = 32'h0; networkReady = 1'b1;
    replyValid = 1'b0; replyRequesterAddress = 4'h0; replyWriteAck = 1'b0; replyData = 32'h0;
    tick(); tick();
    reset = 1'b0;
    check("rst_ready", 64'(coreReady), 64'h1);
    check("rst_read", 64'(readOut), 64'h0);
    check("rst_write", 64'(writeOut), 64'h0);
    check("rst_resp", 64'(coreRespValid), 64'h0);
    check("rst_dest", 64'(destinationAddressOut), 64'h0);
    check("rst_drop", 64'(droppedReplies), 64'h0);

    // Scenario 1: read
    request(1'b0, 12'hA10, 32'h0);
    check("rd_readOut", 64'(readOut), 64'h1);
    check("rd_writeOut", 64'(writeOut), 64'h0);
    check("rd_dest", 64'(destinationAddressOut), 64'hA10);
    check("rd_reqaddr", 64'(requesterAddressOut), 64'h5);
    check("rd_busy", 64'(coreReady), 64'h0);
    tick();
    check("rd_single_pkt", 64'(readOut), 64'h0);
    reply(4'h5, 1'b0, 32'hDEADBEEF);
    check("rd_respValid", 64'(coreRespValid), 64'h1);
    check("rd_respData", 64'(coreRespData), 64'hDEADBEEF);
    check("rd_error", 64'(coreError), 64'h0);
    check("rd_notReady", 64'(coreReady), 64'h0);
    tick();
    check("rd_pulse_end", 64'(coreRespValid), 64'h0);
    check("rd_ready_again", 64'(coreReady), 64'h1);

    // Scenario 2: backpressure
    networkReady = 1'b0;
    request(1'b0, 12'h3C7, 32'h0);
    for (int i = 0; i < 6; i++) begin
      check("bp_readOut_hold", 64'(readOut), 64'h1);
      check("bp_dest_hold", 64'(destinationAddressOut), 64'h3C7);
      if (i == 5) networkReady = 1'b1;
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      check("bp_no_dup", 64'(readOut), 64'h0);
      tick();
    end
    reply(4'h5, 1'b0, 32'h0BADF00D);
    check("bp_respData", 64'(coreRespData), 64'h0BADF00D);
    tick();

    // Scenario 3: filtering, plus a core request ignored while busy
    request(1'b0, 12'h710, 32'h0);
    tick();
    coreReq = 1'b1; coreAddress = 12'hFFF;
    reply(4'h3, 1'b0, 32'h11111111);
    check("flt_drop1", 64'(droppedReplies), 64'h1);
    check("flt_stay1", 64'(coreRespValid), 64'h0);
    reply(4'h5, 1'b1, 32'h22222222);
    coreReq = 1'b0;
    check("flt_drop2", 64'(droppedReplies), 64'h2);
    check("flt_stay2", 64'(coreReady), 64'h0);
    check("flt_ignored_req", 64'(destinationAddressOut), 64'h710);
    tick();
    check("flt_drop_hold", 64'(droppedReplies), 64'h2);
    reply(4'h5, 1'b0, 32'hCAFEF00D);
    check("flt_respValid", 64'(coreRespValid), 64'h1);
    check("flt_respData", 64'(coreRespData), 64'hCAFEF00D);
    tick();
    check("flt_idle", 64'(coreReady), 64'h1);

    // Scenario 5: write
    request(1'b1, 12'hB22, 32'h12345678);
    check("wr_writeOut", 64'(writeOut), 64'h1);
    check("wr_readOut", 64'(readOut), 64'h0);
    check("wr_dataOut", 64'(dataOut), 64'h12345678);
    tick();
    reply(4'h5, 1'b1, 32'hFFFFFFFF);
    check("wr_respValid", 64'(coreRespValid), 64'h1);
    check("wr_respData", 64'(coreRespData), 64'h0);
    check("wr_drop_unchanged", 64'(droppedReplies), 64'h2);
    tick();

`ifdef NI_TIMEOUT_EN
    // Scenario 4: timeout with two resends
    begin
      int pkts = 0;
      int pktCycle[3] = '{0, 0, 0};
      int respCycle = 0;
      request(1'b0, 12'h444, 32'h0);
      for (int c = 1; c <= 40; c++) begin
        if (readOut === 1'b1) begin
          if (pkts < 3) pktCycle[pkts] = c;
          pkts++;
        end
        if (coreRespValid === 1'b1 && respCycle == 0) begin
          respCycle = c;
          check("to_error", 64'(coreError), 64'h1);
          check("to_respData", 64'(coreRespData), 64'h0);
        end
        tick();
      end
      check("to_pkts", 64'(pkts), 64'd3);
      check("to_pkt2_cycle", 64'(pktCycle[1]), 64'd10);
      check("to_pkt3_cycle", 64'(pktCycle[2]), 64'd19);
      check("to_resp_cycle", 64'(respCycle), 64'd28);
    end
`else
    // Without the timeout feature the block waits indefinitely
    request(1'b0, 12'h444, 32'h0);
    for (int c = 0; c < 30; c++) tick();
    check("nto_busy", 64'(coreReady), 64'h0);
    check("nto_noResp", 64'(coreRespValid), 64'h0);
    check("nto_error", 64'(coreError), 64'h0);
    reply(4'h5, 1'b0, 32'h5A5A5A5A);
    check("nto_respData", 64'(coreRespData), 64'h5A5A5A5A);
    tick();
`endif

    // Scenario 6: reset in WAIT_RESP
    request(1'b0, 12'h123, 32'h0);
    tick();
    reset = 1'b1;
    #1;
    check("rr_ready", 64'(coreReady), 64'h1);
    check("rr_read", 64'(readOut), 64'h0);
    check("rr_dest", 64'(destinationAddressOut), 64'h0);
    check("rr_reqaddr", 64'(requesterAddressOut), 64'h0);
    check("rr_drop", 64'(droppedReplies), 64'h0);
    tick();
    reset = 1'b0;
    reply(4'h5, 1'b0, 32'h77777777);
    check("rr_late_drop", 64'(droppedReplies), 64'h1);
    check("rr_no_resp", 64'(coreRespValid), 64'h0);
    tick();
    check("rr_no_resp2", 64'(coreRespValid), 64'h0);
    check("rr_idle", 64'(coreReady), 64'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
